// File: rtl/hazard_unit_if.sv
//------------------------------------------------------------------------------
// hazard_unit_if: decode/execute usage in, forwarding/stall/flush/counters out.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_unit_if #(
  parameter int CNTW = 16
);
  logic [3:0]      RA1D;
  logic [3:0]      RA2D;
  logic [3:0]      WA3D;
  logic            RegWriteD;
  logic            MemtoRegD;
  logic            PCSrcD;
  logic            CondExE;
  logic            BranchTakenE;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic            FlushE;
  logic [CNTW-1:0] StallCount;
  logic [CNTW-1:0] FlushCount;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount
  );
endinterface

`default_nettype wire

// File: rtl/hazard_unit.sv
//------------------------------------------------------------------------------
// hazard_unit: shadow E/M/W destination tracking, forwarding, stalls, flushes
// and saturating stall/flush event counters. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_unit #(
  parameter int CNTW = 16
) (
  input  logic        clk,
  input  logic        reset,
  hazard_unit_if.slave hz
);

  logic [3:0]      ra1_e_q, ra2_e_q, wa3_e_q, wa3_m_q, wa3_w_q;
  logic            regwr_e_q, memtoreg_e_q, pcsrc_e_q;
  logic            regwr_m_q, pcsrc_m_q, regwr_w_q, pcsrc_w_q;
  logic [CNTW-1:0] stall_cnt_q, flush_cnt_q;

  logic            ldr_stall, pc_pending, stall_d, flush_e;
  logic [1:0]      fwd_a, fwd_b;

  always_comb begin
    ldr_stall  = memtoreg_e_q & regwr_e_q &
                 ((hz.RA1D == wa3_e_q) | (hz.RA2D == wa3_e_q));
    pc_pending = hz.PCSrcD | pcsrc_e_q | pcsrc_m_q;
    stall_d    = ~reset & ldr_stall;
    flush_e    = reset | ldr_stall | hz.BranchTakenE;
  end

  // Memory stage wins over Writeback; R15 reads the PC and is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset && ra1_e_q != 4'hF) begin
      if (regwr_m_q && ra1_e_q == wa3_m_q)      fwd_a = 2'b10;
      else if (regwr_w_q && ra1_e_q == wa3_w_q) fwd_a = 2'b01;
    end
    if (!reset && ra2_e_q != 4'hF) begin
      if (regwr_m_q && ra2_e_q == wa3_m_q)      fwd_b = 2'b10;
      else if (regwr_w_q && ra2_e_q == wa3_w_q) fwd_b = 2'b01;
    end
  end

  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.StallF     = ~reset & (ldr_stall | pc_pending);
  assign hz.StallD     = stall_d;
  assign hz.FlushD     = reset | pc_pending | pcsrc_w_q | hz.BranchTakenE;
  assign hz.FlushE     = flush_e;
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ra1_e_q      <= 4'h0;
      ra2_e_q      <= 4'h0;
      wa3_e_q      <= 4'h0;
      regwr_e_q    <= 1'b0;
      memtoreg_e_q <= 1'b0;
      pcsrc_e_q    <= 1'b0;
      wa3_m_q      <= 4'h0;
      regwr_m_q    <= 1'b0;
      pcsrc_m_q    <= 1'b0;
      wa3_w_q      <= 4'h0;
      regwr_w_q    <= 1'b0;
      pcsrc_w_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (flush_e) begin
        ra1_e_q      <= 4'h0;
        ra2_e_q      <= 4'h0;
        wa3_e_q      <= 4'h0;
        regwr_e_q    <= 1'b0;
        memtoreg_e_q <= 1'b0;
        pcsrc_e_q    <= 1'b0;
      end else begin
        ra1_e_q      <= hz.RA1D;
        ra2_e_q      <= hz.RA2D;
        wa3_e_q      <= hz.WA3D;
        regwr_e_q    <= hz.RegWriteD;
        memtoreg_e_q <= hz.MemtoRegD;
        pcsrc_e_q    <= hz.PCSrcD;
      end
      // A failed condition kills the write before it can be forwarded.
      wa3_m_q   <= wa3_e_q;
      regwr_m_q <= regwr_e_q & hz.CondExE;
      pcsrc_m_q <= pcsrc_e_q & hz.CondExE;
      wa3_w_q   <= wa3_m_q;
      regwr_w_q <= regwr_m_q;
      pcsrc_w_q <= pcsrc_m_q;
      if (stall_d && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNTW'(1);
      if (flush_e && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNTW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
//------------------------------------------------------------------------------
// tb_hazard_unit: directed scenarios plus randomized run against an
// instruction-level model of the pipeline. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] ra1d, ra2d, wa3d;
  logic rwd, mtrd, pcsd, conde, bte;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.CNTW(16)) hz16 ();
  hazard_unit_if #(.CNTW(4))  hz4 ();

  assign hz16.RA1D = ra1d;          assign hz4.RA1D = ra1d;
  assign hz16.RA2D = ra2d;          assign hz4.RA2D = ra2d;
  assign hz16.WA3D = wa3d;          assign hz4.WA3D = wa3d;
  assign hz16.RegWriteD = rwd;      assign hz4.RegWriteD = rwd;
  assign hz16.MemtoRegD = mtrd;     assign hz4.MemtoRegD = mtrd;
  assign hz16.PCSrcD = pcsd;        assign hz4.PCSrcD = pcsd;
  assign hz16.CondExE = conde;      assign hz4.CondExE = conde;
  assign hz16.BranchTakenE = bte;   assign hz4.BranchTakenE = bte;

  hazard_unit #(.CNTW(16)) u_dut16 (.clk(clk), .reset(rst), .hz(hz16.slave));
  hazard_unit #(.CNTW(4))  u_dut4  (.clk(clk), .reset(rst), .hz(hz4.slave));

  // Instruction records occupying E (0), M (1) and W (2).
  typedef struct packed {
    logic [3:0] ra1, ra2, wa;
    logic       rw, ld, pc;
  } ins_t;
  ins_t st [3];
  int sc16, fc16, sc4, fc4;

  function automatic logic m_ldr();
    return st[0].ld && st[0].rw && (ra1d == st[0].wa || ra2d == st[0].wa);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [3:0] ra);
    if (ra == 4'hF) return 2'b00;
    for (int k = 1; k <= 2; k++)
      if (st[k].rw && st[k].wa == ra) return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  // {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}
  function automatic logic [7:0] m_out();
    logic ldr, pend;
    if (rst) return 8'b0000_0011;
    ldr  = m_ldr();
    pend = pcsd | st[0].pc | st[1].pc;
    return {m_fwd(st[0].ra1), m_fwd(st[0].ra2), ldr | pend, ldr,
            pend | st[2].pc | bte, ldr | bte};
  endfunction

  task automatic drive(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                       input logic rw, input logic ld, input logic pc,
                       input logic cond, input logic bt);
    ra1d = a1; ra2d = a2; wa3d = w; rwd = rw; mtrd = ld; pcsd = pc;
    conde = cond; bte = bt;
  endtask

  task automatic tick();
    logic sd, fe;
    @(posedge clk);
    sd = m_ldr();
    fe = sd | bte;
    if (rst) begin
      for (int k = 0; k < 3; k++) st[k] = '0;
      sc16 = 0; fc16 = 0; sc4 = 0; fc4 = 0;
    end else begin
      if (sd) begin
        sc16 = (sc16 < 65535) ? sc16 + 1 : sc16;
        sc4  = (sc4 < 15) ? sc4 + 1 : sc4;
      end
      if (fe) begin
        fc16 = (fc16 < 65535) ? fc16 + 1 : fc16;
        fc4  = (fc4 < 15) ? fc4 + 1 : fc4;
      end
      st[2] = st[1];
      st[1] = st[0];
      st[1].rw = st[0].rw & conde;
      st[1].pc = st[0].pc & conde;
      st[0] = fe ? '0 : {ra1d, ra2d, wa3d, rwd, mtrd, pcsd};
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 1, 1, 0, 0, 1, 0);
    tick();
    @(negedge clk);
    n_checks++;
    if ({hz16.StallF, hz16.StallD, hz16.FlushD, hz16.FlushE} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 0011",
               {hz16.StallF, hz16.StallD, hz16.FlushD, hz16.FlushE});
    end
    n_checks++;
    if ({hz16.StallCount, hz16.FlushCount} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt got %h/%h want 0/0", hz16.StallCount, hz16.FlushCount);
    end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if ({hz16.ForwardAE, hz16.ForwardBE, hz16.StallF, hz16.FlushD, hz16.FlushE} !== 7'b0) begin
      n_fail++;
      $display("FAIL release got %b want 0000000",
               {hz16.ForwardAE, hz16.ForwardBE, hz16.StallF, hz16.FlushD, hz16.FlushE});
    end
    tick();
  endtask

  task automatic test_alu_forward();
    // ADD R1 then SUB R1 immediately: Memory forward
    do_reset();
    drive(0, 0, 1, 1, 0, 0, 1, 0); tick();
    drive(1, 0, 4, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if (hz16.ForwardAE !== 2'b10) begin
      n_fail++; $display("FAIL fwd_mem got %b want 10", hz16.ForwardAE);
    end
    tick();
    // One NOP between: Writeback forward
    do_reset();
    drive(0, 0, 1, 1, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 4, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if ({hz16.ForwardAE, hz16.ForwardBE} !== 4'b0100) begin
      n_fail++; $display("FAIL fwd_wb got %b want 0100", {hz16.ForwardAE, hz16.ForwardBE});
    end
    tick();
    // Match in both M and W: Memory wins
    do_reset();
    drive(0, 0, 1, 1, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 0, 0, 1, 0); tick();
    drive(1, 1, 4, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if ({hz16.ForwardAE, hz16.ForwardBE} !== 4'b1010) begin
      n_fail++; $display("FAIL fwd_prio got %b want 1010", {hz16.ForwardAE, hz16.ForwardBE});
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 0, 2, 1, 1, 0, 1, 0); tick();
    drive(5, 2, 6, 1, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if ({hz16.StallF, hz16.StallD, hz16.FlushE} !== 3'b111) begin
      n_fail++; $display("FAIL ldr_stall got %b want 111", {hz16.StallF, hz16.StallD, hz16.FlushE});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({hz16.StallF, hz16.StallD, hz16.FlushE} !== 3'b000) begin
      n_fail++; $display("FAIL ldr_release got %b want 000", {hz16.StallF, hz16.StallD, hz16.FlushE});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if ({hz16.ForwardAE, hz16.ForwardBE} !== 4'b0001) begin
      n_fail++; $display("FAIL ldr_fwd got %b want 0001", {hz16.ForwardAE, hz16.ForwardBE});
    end
    n_checks++;
    if ({hz16.StallCount, hz16.FlushCount} !== {16'd1, 16'd1}) begin
      n_fail++; $display("FAIL ldr_cnt got %0d/%0d want 1/1", hz16.StallCount, hz16.FlushCount);
    end
    tick();
    // Load-use coinciding with a taken branch flushes E once
    do_reset();
    drive(0, 0, 2, 1, 1, 0, 1, 0); tick();
    drive(2, 0, 6, 1, 0, 0, 1, 1);
    @(negedge clk);
    n_checks++;
    if ({hz16.StallD, hz16.FlushD, hz16.FlushE} !== 3'b111) begin
      n_fail++; $display("FAIL ldr_br got %b want 111", {hz16.StallD, hz16.FlushD, hz16.FlushE});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if (hz16.FlushCount !== 16'd1) begin
      n_fail++; $display("FAIL ldr_br_cnt got %0d want 1", hz16.FlushCount);
    end
    tick();
  endtask

  task automatic test_cond_fail();
    do_reset();
    drive(0, 0, 3, 1, 0, 0, 1, 0); tick();
    drive(3, 0, 7, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
    @(negedge clk);
    n_checks++;
    if (hz16.ForwardAE !== 2'b00) begin
      n_fail++; $display("FAIL cond_fail got %b want 00", hz16.ForwardAE);
    end
    tick();
  endtask

  task automatic test_pc_write();
    logic [4:0] exp_sf, exp_fd;
    exp_sf = 5'b00111;
    exp_fd = 5'b01111;
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({hz16.StallF, hz16.FlushD} !== {exp_sf[i], exp_fd[i]}) begin
        n_fail++;
        $display("FAIL pc_write[%0d] got %b want %b", i, {hz16.StallF, hz16.FlushD},
                 {exp_sf[i], exp_fd[i]});
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
    end
    // Condition fails in E: no PCSrcM, stall and flush stop after E
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if ({hz16.StallF, hz16.FlushD} !== 2'b00) begin
      n_fail++; $display("FAIL pc_cond got %b want 00", {hz16.StallF, hz16.FlushD});
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    n_checks++;
    if ({hz16.FlushD, hz16.FlushE, hz16.StallF} !== 3'b110) begin
      n_fail++; $display("FAIL branch got %b want 110", {hz16.FlushD, hz16.FlushE, hz16.StallF});
    end
    tick();
  endtask

  task automatic test_saturation_r15();
    do_reset();
    for (int i = 0; i < 45; i++) begin
      drive(0, 2, 2, 1, 1, 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if ({hz4.StallCount, hz4.FlushCount} !== 8'hFF) begin
      n_fail++; $display("FAIL saturate got %h/%h want F/F", hz4.StallCount, hz4.FlushCount);
    end
    n_checks++;
    if (hz16.StallCount !== 16'(sc16)) begin
      n_fail++; $display("FAIL sat_wide got %0d want %0d", hz16.StallCount, sc16);
    end
    tick();
    do_reset();
    drive(0, 0, 15, 1, 0, 0, 1, 0); tick();
    drive(15, 15, 4, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if ({hz16.ForwardAE, hz16.ForwardBE} !== 4'b0000) begin
      n_fail++; $display("FAIL r15 got %b want 0000", {hz16.ForwardAE, hz16.ForwardBE});
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) == 0));
      @(negedge clk);
      exp = m_out();
      n_checks++;
      if ({hz16.ForwardAE, hz16.ForwardBE, hz16.StallF, hz16.StallD, hz16.FlushD,
           hz16.FlushE} !== exp) begin
        n_fail++;
        $display("FAIL rand_out[%0d] got %b want %b", i,
                 {hz16.ForwardAE, hz16.ForwardBE, hz16.StallF, hz16.StallD, hz16.FlushD,
                  hz16.FlushE}, exp);
      end
      n_checks++;
      if ({hz16.StallCount, hz16.FlushCount, hz4.StallCount, hz4.FlushCount} !==
          {16'(sc16), 16'(fc16), 4'(sc4), 4'(fc4)}) begin
        n_fail++;
        $display("FAIL rand_cnt[%0d] got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 hz16.StallCount, hz16.FlushCount, hz4.StallCount, hz4.FlushCount,
                 sc16, fc16, sc4, fc4);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) st[k] = '0;
    sc16 = 0; fc16 = 0; sc4 = 0; fc4 = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_cond_fail();
    test_pc_write();
    test_saturation_r15();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
